// File: rtl/cache_arb_pkg.sv
// Shared types for the memory request scheduler: the arbitration FSM state encoding.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_req_scheduler.sv
// Two-requester (I/D) scheduler onto one downstream memory port. D has priority on
// conflicts, but I is forced through after STARVE_LIMIT consecutive contested D grants.
module mem_req_scheduler
    import cache_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_read,
    input  logic         i_write,
    input  logic [31:0]  i_addr,
    input  logic [255:0] i_wdata,
    output logic [255:0] i_rdata,
    output logic         i_resp,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_addr,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic         busy,
    output logic         conflict
);

    localparam int unsigned CntWidth = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntWidth-1:0] StarveMax = CntWidth'(STARVE_LIMIT);

    arb_state_t          state_q, state_d;
    logic [CntWidth-1:0] starve_cnt_q, starve_cnt_d;

    logic i_pend, d_pend;

    assign i_pend  = i_read | i_write;
    assign d_pend  = d_read | d_write;

    // Read data is broadcast to both sides; only the matching resp qualifies it.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;
    assign busy    = (state_q != IDLE);

    // State and starvation counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Grant decision in IDLE, command forwarding and completion while serving.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        conflict     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // pmem_resp is deliberately ignored here.
                if (i_pend && d_pend) begin
                    // Gated so no conflict pulse is reported while reset is held.
                    conflict = rst_n;
                    if (starve_cnt_q >= StarveMax) begin
                        state_d      = SERVE_I;
                        starve_cnt_d = '0;
                    end else begin
                        // Below the limit, so the increment cannot pass StarveMax.
                        state_d      = SERVE_D;
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (d_pend) begin
                    state_d = SERVE_D;
                end else if (i_pend) begin
                    state_d      = SERVE_I;
                    starve_cnt_d = '0;
                end
            end
            SERVE_I: begin
                pmem_read    = i_read;
                pmem_write   = i_write;
                pmem_address = i_addr;
                pmem_wdata   = i_wdata;
                if (pmem_resp) begin
                    i_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            SERVE_D: begin
                pmem_read    = d_read;
                pmem_write   = d_write;
                pmem_address = d_addr;
                pmem_wdata   = d_wdata;
                if (pmem_resp) begin
                    d_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Self-checking bench for mem_req_scheduler: per-cycle vector table plus directed
// sequences for starvation, D write and mid-transaction reset.
module tb_mem_req_scheduler;

    localparam logic [31:0] AddrI = 32'h0000_3000;
    localparam logic [31:0] AddrD = 32'h0000_1000;

    logic         clk;
    logic         rst_n;
    logic         i_read, i_write, d_read, d_write;
    logic [31:0]  i_addr, d_addr;
    logic [255:0] i_wdata, d_wdata;
    logic [255:0] i_rdata, d_rdata;
    logic         i_resp, d_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;
    logic         busy, conflict;

    int n_tests = 0;
    int n_fail  = 0;

    mem_req_scheduler #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read       (i_read),
        .i_write      (i_write),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .busy         (busy),
        .conflict     (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A requester must never raise read and write together.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(i_read && i_write) && !(d_read && d_write))
                else $error("illegal simultaneous read and write request");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // in:  {rst_n, i_read, i_write, d_read, d_write, pmem_resp}
    // out: {busy, pmem_read, pmem_write, i_resp, d_resp, conflict}
    typedef struct {
        logic [5:0]  in_bits;
        logic [5:0]  out_bits;
        logic [31:0] addr;
        logic [2:0]  starve;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic [5:0] in_b, input logic [5:0] out_b,
                                input logic [31:0] a, input logic [2:0] s);
        vec_t v;
        v.in_bits  = in_b;
        v.out_bits = out_b;
        v.addr     = a;
        v.starve   = s;
        return v;
    endfunction

    int         d_grants, confs, extra_resp;
    logic       i_done;
    logic [2:0] max_starve;

    initial begin
        rst_n = 1'b0; i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = AddrI; d_addr = AddrD;
        i_wdata = {8{32'h1111_2222}}; d_wdata = {8{32'h3333_4444}};
        pmem_rdata = '0; pmem_resp = 1'b0;

        // Reset, spurious resp, D-only read (resp on 3rd serve cycle), D vs I conflict.
        vecs[0]  = mk(6'b0_0000_0, 6'b000000, 32'h0, 3'd0);
        vecs[1]  = mk(6'b0_1010_0, 6'b000000, 32'h0, 3'd0);
        vecs[2]  = mk(6'b1_0000_0, 6'b000000, 32'h0, 3'd0);
        vecs[3]  = mk(6'b1_0000_1, 6'b000000, 32'h0, 3'd0);
        vecs[4]  = mk(6'b1_0000_0, 6'b000000, 32'h0, 3'd0);
        vecs[5]  = mk(6'b1_0010_0, 6'b000000, 32'h0, 3'd0);
        vecs[6]  = mk(6'b1_0010_0, 6'b110000, AddrD, 3'd0);
        vecs[7]  = mk(6'b1_0010_0, 6'b110000, AddrD, 3'd0);
        vecs[8]  = mk(6'b1_0010_1, 6'b110010, AddrD, 3'd0);
        vecs[9]  = mk(6'b1_0000_0, 6'b000000, 32'h0, 3'd0);
        vecs[10] = mk(6'b1_1010_0, 6'b000001, 32'h0, 3'd0);
        vecs[11] = mk(6'b1_1010_0, 6'b110000, AddrD, 3'd1);
        vecs[12] = mk(6'b1_1010_1, 6'b110010, AddrD, 3'd1);
        vecs[13] = mk(6'b1_1000_0, 6'b000000, 32'h0, 3'd1);
        vecs[14] = mk(6'b1_1000_0, 6'b110000, AddrI, 3'd0);
        vecs[15] = mk(6'b1_1000_1, 6'b110100, AddrI, 3'd0);
        vecs[16] = mk(6'b1_0000_0, 6'b000000, 32'h0, 3'd0);

        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            {rst_n, i_read, i_write, d_read, d_write, pmem_resp} = vecs[k].in_bits;
            pmem_rdata = {8{32'hC0DE_0000 + 32'(k)}};
            #1;
            check($sformatf("vec%0d", k),
                  256'({busy, pmem_read, pmem_write, i_resp, d_resp, conflict, pmem_address,
                        dut.starve_cnt_q, i_rdata == pmem_rdata, d_rdata == pmem_rdata}),
                  256'({vecs[k].out_bits, vecs[k].addr, vecs[k].starve, 2'b11}));
        end

        // Starvation: both pending continuously, pmem answers on every serve cycle.
        @(negedge clk);
        rst_n = 1'b0; i_read = 1'b0; d_read = 1'b0; pmem_resp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; i_read = 1'b1; d_read = 1'b1;
        d_grants = 0; confs = 0; i_done = 1'b0; max_starve = '0;
        for (int c = 0; c < 60 && !i_done; c++) begin
            if (c > 0) @(negedge clk);
            pmem_resp = busy;
            #1;
            if (d_resp) d_grants++;
            if (conflict) confs++;
            if (i_resp) i_done = 1'b1;
            if (dut.starve_cnt_q > max_starve) max_starve = dut.starve_cnt_q;
        end
        check("starve_i_served", 256'(i_done), 256'(1'b1));
        check("starve_d_grants", 256'(d_grants), 256'(4));
        check("starve_conflicts", 256'(confs), 256'(5));
        check("starve_saturation", 256'(max_starve), 256'(3'd4));
        check("starve_cleared", 256'(dut.starve_cnt_q), 256'(3'd0));
        i_read = 1'b0; d_read = 1'b0;
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        check("starve_back_idle", 256'(busy), 256'(1'b0));

        // D write of an A5 line to 0x2000, resp on the third serve cycle.
        @(negedge clk);
        d_write = 1'b1; d_addr = 32'h0000_2000; d_wdata = {32{8'hA5}};
        #1;
        check("wr_grant_idle", 256'({busy, pmem_write}), 256'(2'b00));
        check("wr_idle_wdata", pmem_wdata, 256'(0));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("wr_serve%0d_cmd", c),
                  256'({busy, pmem_read, pmem_write, d_resp, pmem_address}),
                  256'({4'b1010, 32'h0000_2000}));
            check($sformatf("wr_serve%0d_wdata", c), pmem_wdata, {32{8'hA5}});
        end
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        check("wr_resp", 256'({pmem_write, d_resp, i_resp}), 256'(3'b110));
        check("wr_resp_wdata", pmem_wdata, {32{8'hA5}});
        @(negedge clk);
        d_write = 1'b0; pmem_resp = 1'b0;
        extra_resp = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (d_resp || i_resp) extra_resp++;
            @(negedge clk);
        end
        check("wr_single_resp", 256'(extra_resp), 256'(0));

        // Reset while serving I; a later pmem_resp must not complete anything.
        i_read = 1'b1; i_addr = AddrI;
        @(negedge clk);
        #1;
        check("rst_in_serve_i", 256'({busy, pmem_read, pmem_address}), 256'({2'b11, AddrI}));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; i_read = 1'b0; pmem_resp = 1'b1;
        #1;
        check("rst_abandon0", 256'({busy, pmem_read, i_resp, d_resp, conflict}), 256'(0));
        @(negedge clk);
        #1;
        check("rst_abandon1", 256'({busy, pmem_read, i_resp, d_resp}), 256'(0));
        check("rst_state_idle", 256'(dut.state_q), 256'(2'd0));
        pmem_resp = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_scheduler.md
MEM_REQ_SCHEDULER -- requirements
Module: mem_req_scheduler

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive D grants issued while I is waiting.
REQ-002 SHALL have ports (clk, rst_n first):
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset; synchronous, active-low
i_read / i_write  in  1  I-side line read / write request
i_addr  in  32  I-side line address
i_wdata  in  256  I-side write line
i_rdata  out  256  I-side read line
i_resp  out  1  I-side completion pulse
d_read / d_write / d_addr / d_wdata / d_rdata / d_resp  --  D-side equivalents, same widths and directions
pmem_read / pmem_write  out  1  downstream command
pmem_address  out  32  downstream address
pmem_wdata  out  256  downstream write line
pmem_rdata  in  256  downstream read line
pmem_resp  in  1  downstream completion pulse
busy  out  1  high while a transaction is in flight
conflict  out  1  one-cycle pulse: both sides requesting at a grant decision

Function
REQ-003 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-004 A requester is pending when its read or write is high; requesters hold command, address and wdata stable until their resp.
REQ-005 In IDLE, D only pending -> SERVE_D next cycle; I only pending -> SERVE_I; neither pending -> stay in IDLE.
REQ-006 In IDLE with both pending: grant I if starve_cnt >= STARVE_LIMIT, else grant D; assert conflict that cycle.
REQ-007 starve_cnt SHALL increment when D is granted while I is pending, saturate at STARVE_LIMIT, and clear on any I grant.
REQ-008 In SERVE_x, pmem_read/write/address/wdata SHALL combinationally mirror requester x; in IDLE, pmem_read and pmem_write SHALL be 0 and address/wdata 0.
REQ-009 In SERVE_x with pmem_resp=1: x_resp=1 that same cycle, then next state is IDLE; the other resp stays 0.
REQ-010 i_rdata and d_rdata SHALL both carry pmem_rdata at all times; only resp qualifies it.
REQ-011 Minimum occupancy: 1 IDLE grant cycle + at least 1 SERVE cycle; back-to-back transactions have exactly one IDLE cycle between them.
REQ-012 pmem_resp received in IDLE SHALL be ignored: no resp out, no state change.
REQ-013 busy = 1 exactly in SERVE_I or SERVE_D.
REQ-014 Read and write asserted together by one requester is illegal; the block forwards both unchanged, and the bench asserts it never occurs.

Reset
REQ-015 With rst_n=0 at a clock edge: state=IDLE and starve_cnt=0; from the next cycle, pmem_read, pmem_write, i_resp, d_resp, busy and conflict are all 0.
REQ-016 Reset mid-transaction SHALL abandon the transaction with no resp issued; any later pmem_resp follows REQ-012.

Structure
REQ-017 Shared package cache_arb_pkg SHALL hold the state enum arb_state_t (IDLE, SERVE_I, SERVE_D).
REQ-018 SHALL be a single module with no sub-modules; starve_cnt width = $clog2(STARVE_LIMIT+1).

Verification
REQ-019 D-only read of 0x0000_1000; pmem_resp 3 cycles after grant -> pmem_read=1 with address 0x1000 for 3 cycles, d_resp pulses once, i_resp stays 0.
REQ-020 I and D both reading at the same cycle, STARVE_LIMIT=4 -> D granted, conflict=1, starve_cnt=1; I served next after one IDLE cycle.
REQ-021 D requesting continuously and I pending -> exactly 4 D grants, then I granted; starve_cnt returns to 0.
REQ-022 D write, wdata=256'hA5.., address 0x2000 -> pmem_write=1 and pmem_wdata matches until pmem_resp; d_resp pulses once.
REQ-023 rst_n=0 during SERVE_I, then pmem_resp=1 after reset -> no i_resp, state IDLE, pmem_read=0.
REQ-024 Spurious pmem_resp in IDLE with no requests -> all outputs unchanged, busy=0.
